// File: rtl/smc777_text_pixel_pkg.sv
// Shared constants and types for the smc777 text-mode pixel generator.
// Cell geometry, fetch phases, attribute bit positions and GRB colours live here.
package smc777_text_pixel_pkg;

  localparam int unsigned CHAR_W     = 8;
  localparam int unsigned GLYPH_ROWS = 8;
  localparam int unsigned BLINK_BIT  = 5;
  localparam int unsigned FRAME_W    = 6;
  localparam int unsigned VRAM_AW    = 11;
  localparam int unsigned RA_W       = $clog2(GLYPH_ROWS);
  localparam int unsigned PH_W       = 4;

  localparam logic [PH_W-1:0] PH_LAST_80 = 4'd7;
  localparam logic [PH_W-1:0] PH_LAST_40 = 4'd15;
  localparam logic [PH_W-1:0] PH_VRAM    = 4'd0;
  localparam logic [PH_W-1:0] PH_PCG     = 4'd2;
  localparam logic [PH_W-1:0] PH_GLYPH   = 4'd4;

  localparam int unsigned ATTR_REV   = 3;
  localparam int unsigned ATTR_BLINK = 4;

  localparam logic [2:0] GRB_BLACK = 3'b000;

  typedef struct packed {
    logic [VRAM_AW-1:0] ma;
    logic [4:0]         ra;
    logic               de;
    logic               cursor;
    logic               hsync;
    logic               vsync;
  } crtc_sample_t;

  // Raster rows past the glyph height and non-displayed cells fetch an empty row.
  function automatic logic row_blank(input logic [4:0] ra, input logic de);
    return !de || (ra[4:RA_W] != '0);
  endfunction

endpackage

// File: rtl/smc777_pix_shift.sv
// Glyph row serialiser: parallel load at the cell boundary, shift left towards the MSB.
// In 40-col mode it only shifts on odd phases so every pixel is shown twice.
module smc777_pix_shift
  import smc777_text_pixel_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              load,
  input  logic              double_px,
  input  logic              odd_phase,
  input  logic [CHAR_W-1:0] data,
  output logic              msb
);

  logic [CHAR_W-1:0] sr_q;
  logic              shift_en;

  always_comb begin
    shift_en = ce && (!double_px || odd_phase);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= data;
    end else if (shift_en) begin
      sr_q <= sr_q << 1;
    end
  end

  assign msb = sr_q[CHAR_W-1];

endmodule

// File: rtl/smc777_text_pixel.sv
// Text-mode pixel generator behind the mc6845: character clock, VRAM/PCG fetch,
// attribute/blink/cursor/border colouring and sync re-timing by one cell.
module smc777_text_pixel
  import smc777_text_pixel_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_pix,
  input  logic        width80,
  input  logic [2:0]  border_col,
  output logic        char_ce,
  input  logic [13:0] crtc_ma,
  input  logic [4:0]  crtc_ra,
  input  logic        crtc_de,
  input  logic        crtc_cursor,
  input  logic        crtc_hsync,
  input  logic        crtc_vsync,
  output logic [10:0] vram_addr,
  input  logic [7:0]  vram_q,
  input  logic [7:0]  attr_q,
  output logic [10:0] pcg_addr,
  input  logic [7:0]  pcg_q,
  output logic [2:0]  rgb,
  output logic        de_out,
  output logic        hsync_out,
  output logic        vsync_out
);

  logic [PH_W-1:0]    phase_q, phase_d;
  logic               w80_q, w80_cur, ph_last;
  crtc_sample_t       samp_q;
  logic [7:0]         attr_f_q, glyph_q;
  logic [VRAM_AW-1:0] vram_addr_q, pcg_addr_q;
  logic [2:0]         fg_q;
  logic               de_q, hs_q, vs_q, valid_q;
  logic [FRAME_W-1:0] frame_q;
  logic [CHAR_W-1:0]  glyph_vis, load_bits;
  logic               pix_bit;
  logic               unused_bits;

  assign unused_bits = ^{crtc_ma[13:VRAM_AW], attr_f_q[7:5]};

  always_comb begin
    // Mode is taken fresh at phase 0 and held for the rest of the cell.
    w80_cur   = (phase_q == '0) ? width80 : w80_q;
    ph_last   = (phase_q == (w80_cur ? PH_LAST_80 : PH_LAST_40));
    phase_d   = ph_last ? '0 : phase_q + 1'b1;
    char_ce   = ce_pix && ph_last;
    glyph_vis = (attr_f_q[ATTR_BLINK] && frame_q[BLINK_BIT]) ? '0 : glyph_q;
    load_bits = glyph_vis ^ {CHAR_W{attr_f_q[ATTR_REV]}} ^ {CHAR_W{samp_q.cursor}};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q     <= '0;
      w80_q       <= 1'b1;
      samp_q      <= '0;
      vram_addr_q <= '0;
      pcg_addr_q  <= '0;
      attr_f_q    <= '0;
      glyph_q     <= '0;
      fg_q        <= GRB_BLACK;
      de_q        <= 1'b0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      valid_q     <= 1'b0;
      frame_q     <= '0;
    end else begin
      if (ce_pix) begin
        phase_q <= phase_d;
        if (phase_q == '0) w80_q <= width80;
        case (phase_q)
          PH_VRAM:  vram_addr_q <= samp_q.ma;
          PH_PCG: begin
            attr_f_q   <= attr_q;
            pcg_addr_q <= {vram_q, samp_q.ra[RA_W-1:0]};
          end
          PH_GLYPH: glyph_q <= row_blank(samp_q.ra, samp_q.de) ? '0 : pcg_q;
          default:  ;
        endcase
      end
      if (char_ce) begin
        samp_q  <= '{ma: crtc_ma[VRAM_AW-1:0], ra: crtc_ra, de: crtc_de,
                     cursor: crtc_cursor, hsync: crtc_hsync, vsync: crtc_vsync};
        fg_q    <= attr_f_q[2:0];
        de_q    <= samp_q.de;
        hs_q    <= samp_q.hsync;
        vs_q    <= samp_q.vsync;
        valid_q <= 1'b1;
        if (crtc_vsync && !samp_q.vsync) frame_q <= frame_q + 1'b1;
      end
    end
  end

  smc777_pix_shift u_shift (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce_pix),
    .load      (char_ce),
    .double_px (!w80_cur),
    .odd_phase (phase_q[0]),
    .data      (load_bits),
    .msb       (pix_bit)
  );

  // Nothing has been loaded into the output stage until the first cell boundary.
  always_comb begin
    if (!valid_q) begin
      rgb = GRB_BLACK;
    end else if (!de_q) begin
      rgb = border_col;
    end else begin
      rgb = pix_bit ? fg_q : GRB_BLACK;
    end
  end

  assign vram_addr = vram_addr_q;
  assign pcg_addr  = pcg_addr_q;
  assign de_out    = de_q;
  assign hsync_out = hs_q;
  assign vsync_out = vs_q;

endmodule

// File: tb/tb_smc777_text_pixel.sv
// Self-checking bench for smc777_text_pixel: RAM models, per-cell driver and a
// cell-level reference model (pixels of cell j appear two driven cells later).
module tb_smc777_text_pixel;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce_pix = 1'b1;
  logic        width80 = 1'b1;
  logic [2:0]  border_col = 3'b000;
  logic        char_ce;
  logic [13:0] crtc_ma = '0;
  logic [4:0]  crtc_ra = '0;
  logic        crtc_de = 1'b0, crtc_cursor = 1'b0, crtc_hsync = 1'b0, crtc_vsync = 1'b0;
  logic [10:0] vram_addr, pcg_addr;
  logic [7:0]  vram_q = '0, attr_q = '0, pcg_q = '0;
  logic [2:0]  rgb;
  logic        de_out, hsync_out, vsync_out;

  smc777_text_pixel dut (
    .clk(clk), .reset(reset), .ce_pix(ce_pix), .width80(width80), .border_col(border_col),
    .char_ce(char_ce), .crtc_ma(crtc_ma), .crtc_ra(crtc_ra), .crtc_de(crtc_de),
    .crtc_cursor(crtc_cursor), .crtc_hsync(crtc_hsync), .crtc_vsync(crtc_vsync),
    .vram_addr(vram_addr), .vram_q(vram_q), .attr_q(attr_q), .pcg_addr(pcg_addr),
    .pcg_q(pcg_q), .rgb(rgb), .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  always #5 clk = ~clk;

  logic [7:0] vram_m [2048];
  logic [7:0] attr_m [2048];
  logic [7:0] pcg_m  [2048];

  always @(posedge clk) begin
    vram_q <= vram_m[vram_addr];
    attr_q <= attr_m[vram_addr];
    pcg_q  <= pcg_m[pcg_addr];
  end

  int checks = 0;
  int failures = 0;

  localparam int MAXS = 4096;
  logic [13:0] h_ma  [MAXS];
  logic [4:0]  h_ra  [MAXS];
  bit          h_de  [MAXS];
  bit          h_cur [MAXS];
  bit          h_hs  [MAXS];
  bit          h_vs  [MAXS];
  bit          h_w80 [MAXS];
  int          h_fc  [MAXS];
  int          step_no = 0;
  int          base = 0;
  int          fc_m = 0;
  bit          prev_vs = 1'b0;
  bit          gate_ce = 1'b0;

  logic [2:0]  obs_pix [16];
  int          obs_n;
  logic        obs_de, obs_hs, obs_vs;
  logic [10:0] obs_vaddr, obs_paddr;
  bit          obs_to;

  // Row bits as seen on screen for driven cell j.
  function automatic logic [7:0] exp_bits(int j);
    logic [10:0] a;
    logic [7:0]  ch, at, row;
    a   = h_ma[j][10:0];
    ch  = vram_m[a];
    at  = attr_m[a];
    row = pcg_m[{ch, h_ra[j][2:0]}];
    if (!h_de[j] || h_ra[j] >= 5'd8) row = 8'h00;
    if (at[4] && (h_fc[j] % 64) >= 32) row = 8'h00;
    if (at[3]) row = ~row;
    if (h_cur[j]) row = ~row;
    return row;
  endfunction

  function automatic logic [2:0] exp_pix(int j, int p, bit w80);
    int         b;
    logic [7:0] bits;
    logic [7:0] at;
    b    = w80 ? p : p / 2;
    bits = exp_bits(j);
    at   = attr_m[h_ma[j][10:0]];
    if (!h_de[j]) return border_col;
    return bits[7-b] ? at[2:0] : 3'b000;
  endfunction

  // Drive one cell's CRTC inputs and record what the DUT shows during that cell.
  task automatic step_cell(input logic [13:0] ma, input logic [4:0] ra, input bit de,
                           input bit cur, input bit hs, input bit vs, input bit w80);
    int j;
    j = step_no;
    crtc_ma = ma; crtc_ra = ra; crtc_de = de; crtc_cursor = cur;
    crtc_hsync = hs; crtc_vsync = vs; width80 = w80;
    h_ma[j] = ma; h_ra[j] = ra; h_de[j] = de; h_cur[j] = cur;
    h_hs[j] = hs; h_vs[j] = vs; h_w80[j] = w80;
    if (vs && !prev_vs) fc_m = fc_m + 1;
    prev_vs = vs;
    h_fc[j] = fc_m;
    obs_n = 0;
    obs_to = 1'b1;
    for (int g = 0; g < 200; g++) begin
      ce_pix = gate_ce ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (ce_pix) begin
        if (obs_n < 16) obs_pix[obs_n] = rgb;
        if (obs_n == 0) {obs_de, obs_hs, obs_vs} = {de_out, hsync_out, vsync_out};
        obs_n++;
      end
      if (char_ce) begin
        obs_vaddr = vram_addr;
        obs_paddr = pcg_addr;
        obs_to = 1'b0;
      end
      @(negedge clk);
      if (!obs_to) break;
    end
    step_no++;
  endtask

  task automatic test_reset();
    int first, second;
    @(negedge clk);
    #2;
    reset = 1'b1;
    crtc_ma = '0; crtc_ra = '0; crtc_de = 1'b0; crtc_cursor = 1'b0;
    crtc_hsync = 1'b0; crtc_vsync = 1'b0; width80 = 1'b1; ce_pix = 1'b1;
    border_col = 3'b101;
    #1;
    checks++;
    if ({char_ce, vram_addr, pcg_addr, rgb, de_out, hsync_out, vsync_out} !== '0) begin
      failures++;
      $display("FAIL reset_async: ce=%b va=%h pa=%h rgb=%h de/hs/vs=%b%b%b want all 0",
               char_ce, vram_addr, pcg_addr, rgb, de_out, hsync_out, vsync_out);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({char_ce, vram_addr, pcg_addr, rgb, de_out, hsync_out, vsync_out} !== '0) begin
      failures++;
      $display("FAIL reset_held: ce=%b va=%h pa=%h rgb=%h want all 0",
               char_ce, vram_addr, pcg_addr, rgb);
    end
    reset = 1'b0;
    first = -1;
    second = -1;
    // After n rising edges the phase is n, so the pulse is visible after edge 7 (8th clock).
    for (int n = 1; n <= 40 && second < 0; n++) begin
      @(posedge clk);
      #1;
      if (char_ce) begin
        if (first < 0) first = n;
        else second = n;
      end
    end
    checks++;
    if (first != 7) begin
      failures++;
      $display("FAIL first_char_ce: got edge %0d want 7", first);
    end
    checks++;
    if (second - first != 8) begin
      failures++;
      $display("FAIL char_ce_period80: got %0d want 8", second - first);
    end
    @(posedge clk);
    @(negedge clk);
    base = step_no;
    fc_m = 0;
    prev_vs = 1'b0;
  endtask

  task automatic test_glyph();
    logic [7:0] attrs [3];
    logic [7:0] bits [3];
    bit         curs [3];
    logic [2:0] want;
    attrs = '{8'h07, 8'h0A, 8'h0A};
    bits  = '{8'h81, 8'h7E, 8'h81};
    curs  = '{1'b0, 1'b0, 1'b1};
    gate_ce = 1'b0;
    vram_m[11'h012] = 8'h41;
    pcg_m[11'h20B]  = 8'h81;
    for (int t = 0; t < 3; t++) begin
      attr_m[11'h012] = attrs[t];
      base = step_no;
      repeat (3) step_cell(14'h0012, 5'd3, 1'b1, curs[t], 1'b0, 1'b0, 1'b1);
      checks++;
      if (obs_vaddr !== 11'h012) begin
        failures++;
        $display("FAIL glyph_vram_addr: got %h want 012", obs_vaddr);
      end
      checks++;
      if (obs_paddr !== 11'h20B) begin
        failures++;
        $display("FAIL glyph_pcg_addr: got %h want 20B", obs_paddr);
      end
      for (int p = 0; p < 8; p++) begin
        want = bits[t][7-p] ? attrs[t][2:0] : 3'b000;
        checks++;
        if (obs_pix[p] !== want) begin
          failures++;
          $display("FAIL glyph_pix case %0d px %0d: got %0d want %0d", t, p, obs_pix[p], want);
        end
      end
    end
  endtask

  task automatic test_width40();
    logic [2:0] want;
    gate_ce = 1'b0;
    vram_m[11'h020] = 8'h33;
    attr_m[11'h020] = 8'h07;
    pcg_m[{8'h33, 3'd0}] = 8'hC0;
    base = step_no;
    repeat (3) step_cell(14'h0020, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_n != 16 || obs_to) begin
      failures++;
      $display("FAIL w40_period: got %0d clocks (timeout=%0d) want 16", obs_n, obs_to);
    end
    for (int p = 0; p < 16; p++) begin
      want = (p < 4) ? 3'd7 : 3'd0;
      checks++;
      if (obs_pix[p] !== want) begin
        failures++;
        $display("FAIL w40_pix %0d: got %0d want %0d", p, obs_pix[p], want);
      end
    end
    step_cell(14'h0020, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs_n != 8) begin
      failures++;
      $display("FAIL w40_to_w80_period: got %0d want 8", obs_n);
    end
  endtask

  task automatic test_border();
    int cur, d;
    gate_ce = 1'b0;
    border_col = 3'b100;
    base = step_no;
    for (int s = 0; s < 12; s++) begin
      step_cell(14'($urandom), 5'($urandom_range(0, 7)), 1'b0, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      cur = step_no - 1;
      d = cur - 2;
      if (d >= base) begin
        for (int p = 0; p < 8; p++) begin
          checks++;
          if (obs_pix[p] !== 3'b100) begin
            failures++;
            $display("FAIL border_pix step %0d px %0d: got %0d want 4", s, p, obs_pix[p]);
          end
        end
        checks++;
        if ({obs_de, obs_hs, obs_vs} !== {1'b0, h_hs[d], h_vs[d]}) begin
          failures++;
          $display("FAIL border_sync_lag step %0d: got de/hs/vs=%b%b%b want 0%b%b",
                   s, obs_de, obs_hs, obs_vs, h_hs[d], h_vs[d]);
        end
      end
    end
  endtask

  task automatic test_blink();
    int  cur, d;
    bit  lit;
    gate_ce = 1'b0;
    border_col = 3'b011;
    vram_m[11'h100] = 8'h55;
    attr_m[11'h100] = 8'h15;
    pcg_m[{8'h55, 3'd1}] = 8'hA5;
    base = step_no;
    for (int f = 0; f < 140; f++) begin
      if (f % 2 == 0) step_cell(14'h0100, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      else            step_cell(14'h0100, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      cur = step_no - 1;
      d = cur - 2;
      if (d >= base) begin
        lit = 1'b0;
        for (int p = 0; p < 8; p++) begin
          if (h_de[d] && obs_pix[p] != 3'b000) lit = 1'b1;
          checks++;
          if (obs_pix[p] !== exp_pix(d, p, 1'b1)) begin
            failures++;
            $display("FAIL blink_pix frame %0d px %0d: got %0d want %0d",
                     h_fc[d], p, obs_pix[p], exp_pix(d, p, 1'b1));
          end
        end
        if (h_de[d]) begin
          checks++;
          if (lit != ((h_fc[d] % 64) < 32)) begin
            failures++;
            $display("FAIL blink_phase frame %0d: lit=%0d want %0d",
                     h_fc[d], lit, (h_fc[d] % 64) < 32);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int         cur, d;
    logic [2:0] want;
    logic [7:0] ch;
    for (int i = 0; i < 2048; i++) begin
      vram_m[i] = 8'($urandom);
      attr_m[i] = 8'($urandom);
      pcg_m[i]  = 8'($urandom);
    end
    gate_ce = 1'b1;
    base = step_no;
    for (int s = 0; s < 150; s++) begin
      border_col = 3'($urandom);
      step_cell(14'($urandom), 5'($urandom_range(0, 11)), $urandom_range(0, 3) != 0,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
      cur = step_no - 1;
      d = cur - 2;
      checks++;
      if (obs_to || obs_n != (h_w80[cur] ? 8 : 16)) begin
        failures++;
        $display("FAIL rand_cell_len step %0d: got %0d (timeout=%0d) want %0d",
                 s, obs_n, obs_to, h_w80[cur] ? 8 : 16);
      end
      if (d >= base && !obs_to) begin
        for (int p = 0; p < obs_n && p < 16; p++) begin
          want = exp_pix(d, p, h_w80[cur]);
          checks++;
          if (obs_pix[p] !== want) begin
            failures++;
            $display("FAIL rand_pix step %0d px %0d: got %0d want %0d", s, p, obs_pix[p], want);
          end
        end
        checks++;
        if ({obs_de, obs_hs, obs_vs} !== {h_de[d], h_hs[d], h_vs[d]}) begin
          failures++;
          $display("FAIL rand_sync step %0d: got %b%b%b want %b%b%b", s, obs_de, obs_hs,
                   obs_vs, h_de[d], h_hs[d], h_vs[d]);
        end
      end
      if (cur - 1 >= base && !obs_to) begin
        ch = vram_m[h_ma[cur-1][10:0]];
        checks++;
        if (obs_vaddr !== h_ma[cur-1][10:0] || obs_paddr !== {ch, h_ra[cur-1][2:0]}) begin
          failures++;
          $display("FAIL rand_addr step %0d: got va=%h pa=%h want va=%h pa=%h", s, obs_vaddr,
                   obs_paddr, h_ma[cur-1][10:0], {ch, h_ra[cur-1][2:0]});
        end
      end
    end
    gate_ce = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin
      vram_m[i] = 8'h00;
      attr_m[i] = 8'h00;
      pcg_m[i]  = 8'h00;
    end
    test_reset();
    test_glyph();
    test_width40();
    test_border();
    test_blink();
    test_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
